sseg_scan_capture: RTL

//   Receiving end of the multiplexed 7-segment display bus (SSeg/an) driven by the BCD display path.

---
 rtl/sseg_scan_capture.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_capture.sv
// -----------------------------------------------------------------------------
// sseg_scan_capture
//   Receiving end of a multiplexed 7-segment display bus. It samples the
//   scanned anode/segment lines and waits for each digit to dwell long enough
//   to be trusted. It then decodes the digit back to BCD and assembles one
//   signed result per full scan frame (units, tens, sign, unused digit).
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high reset
//   SSeg         in   7  segment lines, SSeg[0]=a ... SSeg[6]=g
//   an           in   4  anode lines: [0]=units [1]=tens [2]=sign [3]=unused
//   value        out  7  magnitude of the last frame, tens*10+units
//   neg          out  1  sign of the last frame (1 = minus shown)
//   valid        out  1  one-cycle pulse when value/neg are updated
//   err          out  1  one-cycle pulse on an illegal pattern or short frame
//   o_dbg_state  out  2  current FSM state (0=SYNC, 1=COLLECT, 2=PUBLISH)
//
// Handshake: there is no back-pressure. valid and err are single-cycle
// strobes. They are never high together. value/neg are stable whenever valid
// is high and hold until the next valid.
// -----------------------------------------------------------------------------
module sseg_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] SSeg,
  input  logic [3:0] an,
  output logic [6:0] value,
  output logic       neg,
  output logic       valid,
  output logic       err,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  // Counter saturates one above the capture point, so a dwell captures once.
  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_CAP = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

  // Normalised inputs: 1 = digit enabled / segment lit.
  logic [3:0] w_an_n;
  logic [6:0] w_seg_n;
  assign w_an_n  = an   ^ {4{AN_ACTIVE_LOW}};
  assign w_seg_n = SSeg ^ {7{SEG_ACTIVE_LOW}};

  logic [3:0]    r_an, r_prev_an;
  logic [6:0]    r_seg, r_prev_seg;
  logic [CW-1:0] r_cnt;
  logic          w_same;
  logic          w_onehot;
  logic          w_cap;

  assign w_same   = ({r_an, r_seg} == {r_prev_an, r_prev_seg});
  assign w_onehot = (r_prev_an != 4'd0) && ((r_prev_an & (r_prev_an - 4'd1)) == 4'd0);
  // At the capture point r_prev holds a sample that belongs to the stable run.
  assign w_cap    = (r_cnt == CNT_CAP) && w_onehot;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an       <= '0;
      r_seg      <= '0;
      r_prev_an  <= '0;
      r_prev_seg <= '0;
      r_cnt      <= '0;
    end else begin
      r_an       <= w_an_n;
      r_seg      <= w_seg_n;
      r_prev_an  <= r_an;
      r_prev_seg <= r_seg;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Segment decode of the captured sample, pattern listed as {g..a}.
  logic [3:0] w_dig;
  logic       w_is_dig, w_is_blank, w_is_minus;
  always_comb begin
    w_dig      = 4'd0;
    w_is_dig   = 1'b1;
    w_is_blank = 1'b0;
    w_is_minus = 1'b0;
    case (r_prev_seg)
      7'b0111111: w_dig = 4'd0;
      7'b0000110: w_dig = 4'd1;
      7'b1011011: w_dig = 4'd2;
      7'b1001111: w_dig = 4'd3;
      7'b1100110: w_dig = 4'd4;
      7'b1101101: w_dig = 4'd5;
      7'b1111101: w_dig = 4'd6;
      7'b0000111: w_dig = 4'd7;
      7'b1111111: w_dig = 4'd8;
      7'b1101111: w_dig = 4'd9;
      7'b0000000: begin w_is_dig = 1'b0; w_is_blank = 1'b1; end
      7'b1000000: begin w_is_dig = 1'b0; w_is_minus = 1'b1; end
      default:    w_is_dig = 1'b0;
    endcase
  end

  // Digit position from the one-hot anode, and per-position legality.
  logic [1:0] w_k;
  logic       w_legal;
  always_comb begin
    w_k = 2'd0;
    case (r_prev_an)
      4'b0010: w_k = 2'd1;
      4'b0100: w_k = 2'd2;
      4'b1000: w_k = 2'd3;
      default: w_k = 2'd0;
    endcase
    w_legal = 1'b0;
    case (w_k)
      2'd0:    w_legal = w_is_dig;
      2'd1:    w_legal = w_is_dig | w_is_blank;
      2'd2:    w_legal = w_is_blank | w_is_minus;
      default: w_legal = w_is_blank;
    endcase
  end

  state_t     r_state;
  logic [3:0] r_mask;
  logic [3:0] r_units;
  logic [3:0] r_units_new;
  logic [3:0] r_tens;
  logic       r_neg_slot;
  logic [6:0] w_tens_x10;

  assign w_tens_x10  = ({3'b000, r_tens} << 3) + ({3'b000, r_tens} << 1);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SYNC;
      r_mask      <= '0;
      r_units     <= '0;
      r_units_new <= '0;
      r_tens      <= '0;
      r_neg_slot  <= 1'b0;
      value       <= '0;
      neg         <= 1'b0;
      valid       <= 1'b0;
      err         <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (r_state)
        ST_SYNC: begin
          if (w_cap) begin
            if (!w_legal) begin
              err    <= 1'b1;
              r_mask <= '0;
            end else if (w_k == 2'd0) begin
              r_units <= w_dig;
              r_mask  <= 4'b0001;
              r_state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (w_cap) begin
            if (!w_legal) begin
              err     <= 1'b1;
              r_mask  <= '0;
              r_state <= ST_SYNC;
            end else if (w_k == 2'd0) begin
              if (r_mask == 4'b1111) begin
                // Keep the frame's units until the publish cycle has used it.
                r_units_new <= w_dig;
                r_state     <= ST_PUBLISH;
              end else begin
                err     <= 1'b1;
                r_units <= w_dig;
                r_mask  <= 4'b0001;
              end
            end else begin
              if (w_k == 2'd1) r_tens     <= w_is_blank ? 4'd0 : w_dig;
              if (w_k == 2'd2) r_neg_slot <= w_is_minus;
              r_mask[w_k] <= 1'b1;
            end
          end
        end
        ST_PUBLISH: begin
          // Dwell is at least STABLE_CYCLES long, so no capture lands here.
          value   <= w_tens_x10 + {3'b000, r_units};
          neg     <= r_neg_slot;
          valid   <= 1'b1;
          r_units <= r_units_new;
          r_mask  <= 4'b0001;
          r_state <= ST_COLLECT;
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

endmodule
